// File: rtl/spart_driver_if.sv
`default_nettype none
// ============================================================================
//  Module   : spart_driver_if
//  Purpose  : SPART bus-port handshake signals shared between the processor-
//             side driver (master) and the SPART (slave).
//  Signals  : iocs    chip-select strobe          (master -> slave)
//             iorw    1=read, 0=write             (master -> slave)
//             ioaddr  register address            (master -> slave)
//             rda     receive data available      (slave  -> master)
//             tbr     transmit buffer ready       (slave  -> master)
//  Revision : 1.0  initial release
// ============================================================================
interface spart_driver_if;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic       rda;
   logic       tbr;

   modport master (
      output iocs,
      output iorw,
      output ioaddr,
      input  rda,
      input  tbr
   );

   modport slave (
      input  iocs,
      input  iorw,
      input  ioaddr,
      output rda,
      output tbr
   );
endinterface
`default_nettype wire

// File: rtl/spart_driver.sv
`default_nettype none
// ============================================================================
//  Module   : spart_driver
//  Purpose  : Processor-side bus master for the SPART. After reset it loads the
//             baud divisor selected by br_cfg (low byte, then high byte), then
//             echoes every received byte back out through a small FIFO.
//  Ports    : clk       system clock, rising edge
//             rst       asynchronous, active-low reset
//             br_cfg    baud select 00=4800 01=9600 10=19200 11=38400
//             bus       master side of spart_driver_if (iocs/iorw/ioaddr/rda/tbr)
//             databus   bidirectional SPART data bus, driven only on writes
//             cfg_done  divisor for the current br_cfg has been loaded
//             fifo_cnt  number of bytes held in the echo FIFO
//  Revision : 1.0  initial release
// ============================================================================
module spart_driver #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int FIFO_DEPTH = 4
) (
   input  wire                            clk,
   input  wire                            rst,
   input  wire  [1:0]                     br_cfg,
   spart_driver_if.master                 bus,
   // databus stays a discrete port: it is a resolved tristate net shared
   // with the SPART rather than a point-to-point handshake signal.
   inout  wire  [7:0]                     databus,
   output logic                           cfg_done,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_cnt
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam int c_AW = $clog2(FIFO_DEPTH);
   localparam int c_CW = c_AW + 1;

   localparam logic [15:0] c_DIV_4800  = 16'(CLK_HZ / (16 * 4800)  - 1);
   localparam logic [15:0] c_DIV_9600  = 16'(CLK_HZ / (16 * 9600)  - 1);
   localparam logic [15:0] c_DIV_19200 = 16'(CLK_HZ / (16 * 19200) - 1);
   localparam logic [15:0] c_DIV_38400 = 16'(CLK_HZ / (16 * 38400) - 1);

   localparam logic [1:0] c_ADDR_BUF    = 2'b00;
   localparam logic [1:0] c_ADDR_DIV_LO = 2'b10;
   localparam logic [1:0] c_ADDR_DIV_HI = 2'b11;

   localparam logic [c_CW-1:0] c_FULL_CNT = c_CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_LOAD_LO = 3'd0,
      S_GAP1    = 3'd1,
      S_LOAD_HI = 3'd2,
      S_IDLE    = 3'd3,
      S_RD      = 3'd4,
      S_WR      = 3'd5,
      S_GAP     = 3'd6
   } state_t;

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   state_t            state_q,  state_d;
   logic [1:0]        cfg_q,    cfg_d;
   logic              init_q,   init_d;
   logic              cfg_done_q, cfg_done_d;

   logic              iocs_q,   iocs_d;
   logic              iorw_q,   iorw_d;
   logic [1:0]        ioaddr_q, ioaddr_d;
   logic [7:0]        dout_q,   dout_d;

   logic [7:0]        mem_q [FIFO_DEPTH];
   logic [7:0]        mem_d [FIFO_DEPTH];
   logic [c_AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [c_AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [c_CW-1:0]   cnt_q,    cnt_d;

   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic [15:0]       w_div_d;

   assign w_full  = (cnt_q == c_FULL_CNT);
   assign w_empty = (cnt_q == '0);

   // Divisor for the configuration being loaded; uses cfg_d so that the very
   // first low-byte strobe already reflects the br_cfg sampled on that edge.
   always_comb begin
      w_div_d = c_DIV_9600;
      case (cfg_d)
         2'b00:   w_div_d = c_DIV_4800;
         2'b01:   w_div_d = c_DIV_9600;
         2'b10:   w_div_d = c_DIV_19200;
         default: w_div_d = c_DIV_38400;
      endcase
   end

   // -------------------------------------------------------------------------
   // Next-state and FIFO update
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      cfg_d      = cfg_q;
      init_d     = init_q;
      cfg_done_d = cfg_done_q;
      w_push     = 1'b0;
      w_pop      = 1'b0;

      case (state_q)
         S_LOAD_LO: begin
            // Out of reset the state register already sits in LOAD_LO, but
            // br_cfg has not been captured yet: spend one edge sampling it
            // and re-enter LOAD_LO, which launches the low-byte strobe.
            if (!init_q) begin
               cfg_d  = br_cfg;
               init_d = 1'b1;
            end else begin
               state_d = S_GAP1;
            end
         end
         S_GAP1: begin
            state_d = S_LOAD_HI;
         end
         S_LOAD_HI: begin
            state_d    = S_IDLE;
            cfg_done_d = 1'b1;
         end
         S_IDLE: begin
            if (br_cfg != cfg_q) begin
               cfg_d      = br_cfg;
               cfg_done_d = 1'b0;
               state_d    = S_LOAD_LO;
            end else if (bus.rda && !w_full) begin
               state_d = S_RD;
            end else if (bus.tbr && !w_empty) begin
               state_d = S_WR;
            end
         end
         S_RD: begin
            // This edge ends the read strobe: the SPART is driving the byte.
            w_push  = 1'b1;
            state_d = S_GAP;
         end
         S_WR: begin
            w_pop   = 1'b1;
            state_d = S_GAP;
         end
         S_GAP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      // Reads and writes occupy distinct states, so push and pop never
      // coincide and the count moves by at most one.
      if (w_push) begin
         mem_d[wr_ptr_q] = databus;
         wr_ptr_d        = wr_ptr_q + 1'b1;
         cnt_d           = cnt_q + 1'b1;
      end else if (w_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         cnt_d    = cnt_q - 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // Bus outputs: registered decode of the state being entered, so a strobe
   // is glitch-free and lasts exactly the cycle spent in that state.
   // -------------------------------------------------------------------------
   always_comb begin
      iocs_d   = 1'b0;
      iorw_d   = 1'b1;
      ioaddr_d = c_ADDR_BUF;
      dout_d   = dout_q;

      case (state_d)
         S_LOAD_LO: begin
            iocs_d   = 1'b1;
            iorw_d   = 1'b0;
            ioaddr_d = c_ADDR_DIV_LO;
            dout_d   = w_div_d[7:0];
         end
         S_LOAD_HI: begin
            iocs_d   = 1'b1;
            iorw_d   = 1'b0;
            ioaddr_d = c_ADDR_DIV_HI;
            dout_d   = w_div_d[15:8];
         end
         S_RD: begin
            iocs_d   = 1'b1;
         end
         S_WR: begin
            // WR is only entered from IDLE, where no push or pop happens,
            // so the head entry is stable on this edge.
            iocs_d   = 1'b1;
            iorw_d   = 1'b0;
            dout_d   = mem_q[rd_ptr_q];
         end
         default: begin
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_LOAD_LO;
         cfg_q      <= 2'b00;
         init_q     <= 1'b0;
         cfg_done_q <= 1'b0;
         iocs_q     <= 1'b0;
         iorw_q     <= 1'b1;
         ioaddr_q   <= c_ADDR_BUF;
         dout_q     <= 8'h00;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else begin
         state_q    <= state_d;
         cfg_q      <= cfg_d;
         init_q     <= init_d;
         cfg_done_q <= cfg_done_d;
         iocs_q     <= iocs_d;
         iorw_q     <= iorw_d;
         ioaddr_q   <= ioaddr_d;
         dout_q     <= dout_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         mem_q      <= mem_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign bus.iocs   = iocs_q;
   assign bus.iorw   = iorw_q;
   assign bus.ioaddr = ioaddr_q;
   assign databus    = (iocs_q && !iorw_q) ? dout_q : 8'hzz;
   assign cfg_done   = cfg_done_q;
   assign fifo_cnt   = cnt_q;

endmodule
`default_nettype wire
